// File: rtl/carry_mult_seq.sv
// carry_mult_seq: shift-and-add multiplier controller, one AND-gated carry-chain row per cycle
module carry_mult_seq #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               C,
  input  logic               CLR,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state;
  logic [WIDTH-1:0]   mreg;
  logic [WIDTH-1:0]   pp;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [CNT_W-1:0]   cnt;
  // partial-product row gated by the current multiplier LSB, added to the upper product half
  always_comb begin
    pp  = mreg & {WIDTH{prod[0]}};
    sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, pp};
  end
  assign p = prod;
  // controller FSM; the adder carry shifts into the product MSB on every iteration
  always_ff @(posedge C or negedge CLR) begin
    if (!CLR) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      prod      <= '0;
      busy      <= 1'b0;
      cnt       <= '0;
      mreg      <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            state    <= RUN;
            mreg     <= a;
            prod     <= {{WIDTH{1'b0}}, b};
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end else begin
            prod <= {sum, prod[WIDTH-1:1]};
            cnt  <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (abort || out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
